// File: rtl/fsm_xy_packer_if.sv
// Bundles the capture controls, the sampled x/y pair and the byte read port of fsm_xy_packer.
// The master modport is the side that drives the capture window and reads bytes out.
interface fsm_xy_packer_if;
  logic       start;
  logic       stop;
  logic       x;
  logic       y;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       overflow;
  logic       busy;

  modport master (
    output start, stop, x, y, outReady,
    input  outData, outValid, overflow, busy
  );

  modport slave (
    input  start, stop, x, y, outReady,
    output outData, outValid, overflow, busy
  );
endinterface

// File: rtl/fsm_xy_packer.sv
// Packs {x,y} pairs sampled inside a start/stop window into bytes (slot k -> bits 2k+1:2k)
// and queues them in a DEPTH-entry FIFO read through a valid/ready port.
module fsm_xy_packer #(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rstN,
  fsm_xy_packer_if.slave    bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    slot;
  logic [7:0]    pack;
  logic          busyR;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [AW:0]   count;
  logic          overflowR;

  logic [7:0]    pairShifted;
  logic [7:0]    packNext;
  logic [7:0]    pushByte;
  logic          pushEn;
  logic          pushAcc;
  logic          pop;
  logic          full;
  logic          startAcc;

  // The pair being captured this cycle is merged before the push, so slot 3 completes the byte.
  always_comb begin
    pairShifted = 8'({bus.x, bus.y}) << {slot, 1'b0};
    packNext    = pack | pairShifted;
    pushEn      = 1'b0;
    pushByte    = packNext;
    if (state == COLLECT && slot == 2'd3) begin
      pushEn = 1'b1;
    end else if (state == FLUSH) begin
      pushEn   = 1'b1;
      pushByte = pack;
    end
  end

  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = (count != '0) && bus.outReady;
  assign pushAcc  = pushEn && (!full || pop);
  assign startAcc = (state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      slot  <= 2'd0;
      pack  <= 8'h00;
      busyR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= COLLECT;
            slot  <= 2'd0;
            pack  <= 8'h00;
            busyR <= 1'b1;
          end
        end
        COLLECT: begin
          slot <= slot + 2'd1;
          pack <= (slot == 2'd3) ? 8'h00 : packNext;
          // A stop that lands on the last slot has nothing left to flush.
          if (bus.stop) begin
            if (slot == 2'd3) begin
              state <= IDLE;
              busyR <= 1'b0;
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          state <= IDLE;
          slot  <= 2'd0;
          pack  <= 8'h00;
          busyR <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busyR <= 1'b0;
        end
      endcase
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      overflowR <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (startAcc) begin
        overflowR <= 1'b0;
      end else if (pushEn && !pushAcc) begin
        overflowR <= 1'b1;
      end
      if (pushAcc) begin
        mem[wrPtr] <= pushByte;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({pushAcc, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.outData  = mem[rdPtr];
  assign bus.outValid = (count != '0);
  assign bus.overflow = overflowR;
  assign bus.busy     = busyR;

endmodule
